// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and shared helpers for the VGA timing path.
// Coordinates are unsigned COORD_W-bit counts throughout.
package vga_timing_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;

   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int DEF_TICK_DIV  = 4;

   localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   // Inclusive window test on an unsigned coordinate.
   function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-enable divider: one-clk p_tick every TICK_DIV clks, high while the
// phase counter sits at TICK_DIV-1.
module vga_tick_div #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int               CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         p_tick <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         p_tick <= (cnt_next == CNT_LAST);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel/line counters, sync and blanking
// decode, and per-line / per-frame start pulses aligned with p_tick.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter int TICK_DIV  = DEF_TICK_DIV
) (
   input  logic               clk,
   input  logic               reset,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               p_tick,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_LO = H_DISPLAY + H_FRONT;
   localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC - 1;
   localparam int V_SYNC_LO = V_DISPLAY + V_FRONT;
   localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC - 1;

   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

   if ((H_TOTAL > (1 << COORD_W)) || (V_TOTAL > (1 << COORD_W))) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
   end
   if (TICK_DIV < 2) begin : g_bad_div
      $error("vga_timing_gen: TICK_DIV must be at least 2");
   end

   logic [COORD_W-1:0] x_next;
   logic [COORD_W-1:0] y_next;
   logic               h_end;
   logic               v_end;

   vga_tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_div (
      .clk    (clk),
      .reset  (reset),
      .p_tick (p_tick)
   );

   // NOTE: every output of this block gets a default first, so no path through
   // the ifs can leave one unassigned and infer a latch.
   always_comb begin
      x_next = x;
      y_next = y;
      if (p_tick) begin
         if (x == H_LAST) begin
            x_next = '0;
            y_next = (y == V_LAST) ? '0 : y + 1'b1;
         end else begin
            x_next = x + 1'b1;
         end
      end
   end

   // Decodes are taken from the values being loaded so they land on the same
   // edge as x/y with no skew.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x        <= '0;
         y        <= '0;
         hsync    <= 1'b1;
         vsync    <= 1'b1;
         video_on <= 1'b0;
         h_end    <= 1'b0;
         v_end    <= 1'b0;
      end else begin
         x        <= x_next;
         y        <= y_next;
         hsync    <= !in_window(x_next, H_SYNC_LO, H_SYNC_HI);
         vsync    <= !in_window(y_next, V_SYNC_LO, V_SYNC_HI);
         video_on <= in_window(x_next, 0, H_DISPLAY - 1) && in_window(y_next, 0, V_DISPLAY - 1);
         h_end    <= (x_next == H_LAST);
         v_end    <= (y_next == V_LAST);
      end
   end

   // Both operands are flops; the pulses sit in the p_tick clk that performs the wrap.
   assign line_start  = p_tick & h_end;
   assign frame_start = line_start & v_end;

endmodule
